// File: rtl/result_collector.sv
// Collects ITERATIONS accepted samples into a wrapping sum and a rotate-XOR checksum, then hands the result off over valid/ready.
// Optional feature: define RESULT_COLLECTOR_MINMAX_EN to add per-run res_min/res_max outputs.
module result_collector #(
    parameter int ITERATIONS = 100,
    parameter int DATA_W     = 8,
    parameter int SUM_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_out,
    input  logic              valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [SUM_W-1:0]  res_chk,
    output logic [15:0]       res_count,
    output logic              busy,
    output logic [2:0]        err,
    input  logic              err_clr
`ifdef RESULT_COLLECTOR_MINMAX_EN
    ,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max
`endif
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [15:0] LAST_IDX = 16'(ITERATIONS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SUM_W-1:0]   r_sum;
    logic [SUM_W-1:0]   r_chk;
    logic [15:0]        r_count;
    logic [2:0]         r_err;
    logic               w_clear;
    logic               w_acc;
    logic [2:0]         w_err_set;
    logic [SUM_W-1:0]   w_sample;

    assign w_sample = SUM_W'(data_out);

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_acc       = 1'b0;
        w_err_set   = 3'b000;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = COLLECT;
                end else if (valid) begin
                    w_err_set[1] = 1'b1;
                end
            end
            COLLECT: begin
                // A restart discards this cycle's sample and reopens the run.
                if (start) begin
                    w_clear      = 1'b1;
                    w_err_set[0] = 1'b1;
                end else if (valid) begin
                    w_acc = 1'b1;
                    if (r_count == LAST_IDX)
                        w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_err_set[2] = 1'b1;
                    w_state_nxt  = COLLECT;
                end else begin
                    if (valid)
                        w_err_set[1] = 1'b1;
                    if (res_ready)
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_chk   <= '0;
            r_count <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (err_clr ? 3'b000 : r_err) | w_err_set;
            if (w_clear) begin
                r_sum   <= '0;
                r_chk   <= '0;
                r_count <= '0;
            end else if (w_acc) begin
                r_sum   <= r_sum + w_sample;
                r_chk   <= {r_chk[SUM_W-2:0], r_chk[SUM_W-1]} ^ w_sample;
                r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
            end
        end
    end

`ifdef RESULT_COLLECTOR_MINMAX_EN
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= '0;
            r_max <= '0;
        end else if (w_clear) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_acc) begin
            if (data_out < r_min) r_min <= data_out;
            if (data_out > r_max) r_max <= data_out;
        end
    end

    assign res_min = r_min;
    assign res_max = r_max;
`endif

    assign res_valid = (r_state == DONE);
    assign busy      = (r_state == COLLECT);
    assign res_sum   = r_sum;
    assign res_chk   = r_chk;
    assign res_count = r_count;
    assign err       = r_err;

endmodule
